pcd_pause_decoder: RTL and testbench
====================================

Name: pcd_pause_decoder

Overview:
- PICC-side receiver for PCD→PICC Modified Miller frames.
- Consumes the analogue core's asynchronous pause_n and the PICC clock, which halts during pauses.
- Classifies the clock-tick interval between successive pause ends and emits one PCDBitSequence (X/Y/Z/ERROR) per cycle, plus start-of-comm, end-of-comm and error pulses.
- Feeds the frame/bit decoder.

Parameters:
- BIT_TIME, 128, nominal carrier ticks per bit; documentation only, all thresholds below are explicit.
- T_MIN, 64, intervals below this are a decode error.
- T_1P5, 136, interval ≥ this is classed 1.5 bits; otherwise 1 bit.
- T_2, 200, interval ≥ this is classed 2 bits.
- T_TIMEOUT, 288, counter value at which a missing pause means end of frame (error recovery also uses it).

Ports:
- clk  in  1  PICC clock; stops during pauses.
- rst_n  in  1  synchronous active-low reset.
- pause_n  in  1  raw async pause detector output; low = pause.
- seq_valid  out  1  one-cycle strobe, seq is valid.
- seq  out  PCDBitSequence  decoded sequence.
- soc  out  1  pulses with the first Z of a frame.
- eoc  out  1  pulses with the final Y of a frame.
- error  out  1  pulses with seq = ERROR.
- idle  out  1  high in IDLE state.

Behaviour:
- Reset (rst_n low at posedge clk): all strobes 0, seq = PCDBitSequence_ERROR, idle 1, FSM IDLE, counter 0, sync flops 1.
- pause_n passes through a 2-flop synchroniser. The pause-end event pe is a registered rising edge of the synchronised signal.
- Outputs are registered. seq_valid asserts on the 3rd clk posedge after the first posedge that samples pause_n high.
- Interval counter: 9-bit. Cleared on pe, otherwise increments, saturating at T_TIMEOUT.
- Class of the counter value at pe: C1 if T_MIN ≤ cnt < T_1P5; C15 if T_1P5 ≤ cnt < T_2; C2 if T_2 ≤ cnt < T_TIMEOUT; BAD if cnt < T_MIN.
- FSM states: IDLE, LAST_X, LAST_Z, EMIT2, ERR_WAIT.
- IDLE:
  - pe → emit Z, soc=1, go LAST_Z.
  - pause_n low alone emits nothing.
- LAST_Z:
  - pe & C1 → Z.
  - pe & C15 → X, go LAST_X.
  - pe & (C2 | BAD) → ERROR.
  - cnt == T_TIMEOUT → emit Y with eoc=1, go IDLE.
- LAST_X:
  - pe & C1 → X.
  - pe & C15 → Y now, then Z next cycle (via EMIT2), end in LAST_Z.
  - pe & C2 → Y now, then X next cycle, end in LAST_X.
  - pe & BAD → ERROR.
  - cnt == T_TIMEOUT → Y, Y on consecutive cycles; eoc on the second; go IDLE.
- EMIT2: emits the pending sequence unconditionally. The counter keeps running from the pe clear. A pe during EMIT2 is impossible by construction (cnt < T_MIN) and is treated as BAD.
- ERROR path: emit seq=ERROR, seq_valid=1, error=1, go ERR_WAIT.
- ERR_WAIT: each pe clears the counter; at cnt == T_TIMEOUT go IDLE with no output.
- Simultaneous timeout and pe in the same cycle: pe wins.
- Reset mid-frame: immediate return to the reset state; no eoc.
- seq_valid never asserts on two consecutive cycles except for EMIT2 pairs.

Decomposition:
- PCDBitSequence comes from ISO14443A_pkg.
- Add to ISO14443A_pkg: state enum PCDPauseDecoderState, and an interval-class enum (C1/C15/C2/BAD).
- One sub-module: pause_n_synchroniser (2-flop sync plus rising-edge detect, reset value 1).

Test Plan:
- Send Z,Z,Y frame (data 0, 32-tick pauses, default delays) → seq Z(soc),Z,Y(eoc); idle returns 1; error never asserts.
- Send 0x26 short frame (7 bits + EOC) → seq stream matches the modified Miller sequence list exactly, one soc, one eoc.
- X then 1.5-bit gap (X,Y,Z) and X then 2-bit gap (X,Y,X) → Y,Z and Y,X on back-to-back cycles.
- Two pauses 40 ticks apart → seq=ERROR, error=1; no further outputs until 288 idle ticks, then a new frame decodes normally with soc.
- Pause lengths 28 and 48 ticks, clock_stops/starts 200ns/300ns → identical decoded sequences with no errors.
- Assert rst_n mid-frame for 1 cycle → all outputs at reset values next cycle, idle=1, the next frame starts with soc.

Source files
------------

// File: rtl/ISO14443A_pkg.sv
// Shared ISO/IEC 14443-A types for the PICC receive path: the Modified
// Miller sequence alphabet, pause-decoder state encoding, interval classes
// and the helper that classifies a measured pause-to-pause interval.
package ISO14443A_pkg;

  // Modified Miller sequences seen by the PICC. ERROR marks an undecodable
  // interval and doubles as the idle/reset value of the decoder output.
  typedef enum logic [1:0] {
    PCDBitSequence_ERROR = 2'd0,
    PCDBitSequence_X     = 2'd1,
    PCDBitSequence_Y     = 2'd2,
    PCDBitSequence_Z     = 2'd3
  } PCDBitSequence;

  // Pause decoder FSM states.
  //   IDLE     : no frame in progress, waiting for the first pause (SOC).
  //   LAST_X   : the most recent pause was an X.
  //   LAST_Z   : the most recent pause was a Z.
  //   EMIT2    : second half of a two-sequence burst (Y then pending).
  //   ERR_WAIT : swallowing pauses until the line has been quiet long enough.
  typedef enum logic [2:0] {
    PCDPauseDecoderState_IDLE     = 3'd0,
    PCDPauseDecoderState_LAST_X   = 3'd1,
    PCDPauseDecoderState_LAST_Z   = 3'd2,
    PCDPauseDecoderState_EMIT2    = 3'd3,
    PCDPauseDecoderState_ERR_WAIT = 3'd4
  } PCDPauseDecoderState;

  // Class of the clock-tick interval between two successive pause ends.
  typedef enum logic [1:0] {
    PCDIntervalClass_C1  = 2'd0,
    PCDIntervalClass_C15 = 2'd1,
    PCDIntervalClass_C2  = 2'd2,
    PCDIntervalClass_BAD = 2'd3
  } PCDIntervalClass;

  // Width of the interval counter; must hold the timeout value.
  localparam int PCD_CNT_W = 9;

  // Map an interval count onto its class. Anything at or beyond the timeout
  // cannot be a legal in-frame interval, so it is reported as BAD as well.
  function automatic PCDIntervalClass classify_interval(
    input logic [PCD_CNT_W-1:0] cnt,
    input logic [PCD_CNT_W-1:0] t_min,
    input logic [PCD_CNT_W-1:0] t_1p5,
    input logic [PCD_CNT_W-1:0] t_2,
    input logic [PCD_CNT_W-1:0] t_timeout
  );
    PCDIntervalClass cls;
    if (cnt < t_min) begin
      cls = PCDIntervalClass_BAD;
    end else if (cnt < t_1p5) begin
      cls = PCDIntervalClass_C1;
    end else if (cnt < t_2) begin
      cls = PCDIntervalClass_C15;
    end else if (cnt < t_timeout) begin
      cls = PCDIntervalClass_C2;
    end else begin
      cls = PCDIntervalClass_BAD;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pause_n_synchroniser.sv
// Brings the analogue pause detector output into the PICC clock domain and
// produces a registered one-cycle pulse at the end of each pause (rising
// edge of the synchronised pause_n). All sync flops reset to 1 so that a
// line sitting in its no-pause state never produces a spurious event.
module pause_n_synchroniser (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_n,
  output logic pe
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync2_prev_q, sync2_prev_d;
  logic pe_q, pe_d;

  // Next-state: shift the raw input through two stages, remember the last
  // synchronised value and flag a low-to-high transition.
  always_comb begin
    sync1_d      = pause_n;
    sync2_d      = sync1_q;
    sync2_prev_d = sync2_q;
    pe_d         = sync2_q & ~sync2_prev_q;
  end

  // Synchroniser and edge-detect registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      sync2_prev_q <= 1'b1;
      pe_q         <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync2_prev_q <= sync2_prev_d;
      pe_q         <= pe_d;
    end
  end

  assign pe = pe_q;

endmodule

// File: rtl/pcd_pause_decoder.sv
// PICC-side Modified Miller receiver. The PICC clock halts while the PCD
// pauses the field, so the only usable timing is the number of clock ticks
// between successive pause ends. That interval is classified (1, 1.5 or 2
// bit times) and translated into the X/Y/Z sequence stream that the frame
// decoder consumes, together with start/end-of-communication markers.
//
// Output handshake: seq_valid is a one-cycle strobe with no back-pressure;
// seq, soc, eoc and error are meaningful only in a cycle where seq_valid is
// high, and the consumer must take every strobe. Strobes never occur on two
// consecutive cycles except for the Y-plus-pending pair produced via EMIT2.
module pcd_pause_decoder
  import ISO14443A_pkg::*;
#(
  parameter int BIT_TIME  = 128,
  parameter int T_MIN     = 64,
  parameter int T_1P5     = 136,
  parameter int T_2       = 200,
  parameter int T_TIMEOUT = 288
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pause_n,
  output logic          seq_valid,
  output PCDBitSequence seq,
  output logic          soc,
  output logic          eoc,
  output logic          error,
  output logic          idle
);

  // The thresholds are only meaningful if they bracket the nominal bit time
  // in increasing order and the timeout fits in the interval counter.
  if (!(T_MIN < BIT_TIME && BIT_TIME < T_1P5 && T_1P5 < T_2 &&
        T_2 < T_TIMEOUT && T_TIMEOUT < (1 << PCD_CNT_W))) begin : g_bad_thresholds
    $error("pcd_pause_decoder: need T_MIN < BIT_TIME < T_1P5 < T_2 < T_TIMEOUT < 2**PCD_CNT_W");
  end

  localparam logic [PCD_CNT_W-1:0] T_MIN_C     = PCD_CNT_W'(T_MIN);
  localparam logic [PCD_CNT_W-1:0] T_1P5_C     = PCD_CNT_W'(T_1P5);
  localparam logic [PCD_CNT_W-1:0] T_2_C       = PCD_CNT_W'(T_2);
  localparam logic [PCD_CNT_W-1:0] T_TIMEOUT_C = PCD_CNT_W'(T_TIMEOUT);

  logic pe;

  pause_n_synchroniser u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pause_n (pause_n),
    .pe      (pe)
  );

  PCDPauseDecoderState state_q, state_d;
  PCDPauseDecoderState pend_state_q, pend_state_d;
  PCDBitSequence       pend_seq_q, pend_seq_d;
  logic                pend_eoc_q, pend_eoc_d;
  logic [PCD_CNT_W-1:0] cnt_q, cnt_d;

  logic          seq_valid_q, seq_valid_d;
  PCDBitSequence seq_q, seq_d;
  logic          soc_q, soc_d;
  logic          eoc_q, eoc_d;
  logic          error_q, error_d;
  logic          idle_q, idle_d;

  PCDIntervalClass cls;
  logic            timeout;
  logic            do_error;

  assign cls     = classify_interval(cnt_q, T_MIN_C, T_1P5_C, T_2_C, T_TIMEOUT_C);
  assign timeout = (cnt_q == T_TIMEOUT_C);

  // Interval counter: restarts at every pause end, otherwise counts up and
  // parks at the timeout value so a long quiet line stays recognisable.
  always_comb begin
    cnt_d = cnt_q;
    if (pe) begin
      cnt_d = '0;
    end else if (!timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Next-state and registered-output logic. A pause end always takes
  // priority over a timeout seen in the same cycle.
  always_comb begin
    state_d      = state_q;
    pend_state_d = pend_state_q;
    pend_seq_d   = pend_seq_q;
    pend_eoc_d   = pend_eoc_q;
    seq_valid_d  = 1'b0;
    seq_d        = seq_q;
    soc_d        = 1'b0;
    eoc_d        = 1'b0;
    error_d      = 1'b0;
    do_error     = 1'b0;

    case (state_q)
      PCDPauseDecoderState_IDLE: begin
        // First pause of a frame is always the SOC Z.
        if (pe) begin
          seq_valid_d = 1'b1;
          seq_d       = PCDBitSequence_Z;
          soc_d       = 1'b1;
          state_d     = PCDPauseDecoderState_LAST_Z;
        end
      end

      PCDPauseDecoderState_LAST_Z: begin
        if (pe) begin
          case (cls)
            PCDIntervalClass_C1: begin
              seq_valid_d = 1'b1;
              seq_d       = PCDBitSequence_Z;
            end
            PCDIntervalClass_C15: begin
              seq_valid_d = 1'b1;
              seq_d       = PCDBitSequence_X;
              state_d     = PCDPauseDecoderState_LAST_X;
            end
            default: do_error = 1'b1;
          endcase
        end else if (timeout) begin
          // No pause for a whole bit after a Z: the frame ended with Y.
          seq_valid_d = 1'b1;
          seq_d       = PCDBitSequence_Y;
          eoc_d       = 1'b1;
          state_d     = PCDPauseDecoderState_IDLE;
        end
      end

      PCDPauseDecoderState_LAST_X: begin
        if (pe) begin
          case (cls)
            PCDIntervalClass_C1: begin
              seq_valid_d = 1'b1;
              seq_d       = PCDBitSequence_X;
            end
            PCDIntervalClass_C15: begin
              // X, (Y), Z: report the silent Y now, the Z next cycle.
              seq_valid_d  = 1'b1;
              seq_d        = PCDBitSequence_Y;
              pend_seq_d   = PCDBitSequence_Z;
              pend_eoc_d   = 1'b0;
              pend_state_d = PCDPauseDecoderState_LAST_Z;
              state_d      = PCDPauseDecoderState_EMIT2;
            end
            PCDIntervalClass_C2: begin
              // X, (Y), X: report the silent Y now, the X next cycle.
              seq_valid_d  = 1'b1;
              seq_d        = PCDBitSequence_Y;
              pend_seq_d   = PCDBitSequence_X;
              pend_eoc_d   = 1'b0;
              pend_state_d = PCDPauseDecoderState_LAST_X;
              state_d      = PCDPauseDecoderState_EMIT2;
            end
            default: do_error = 1'b1;
          endcase
        end else if (timeout) begin
          // Frame ended after an X: logic 0 (Y) followed by the EOC Y.
          seq_valid_d  = 1'b1;
          seq_d        = PCDBitSequence_Y;
          pend_seq_d   = PCDBitSequence_Y;
          pend_eoc_d   = 1'b1;
          pend_state_d = PCDPauseDecoderState_IDLE;
          state_d      = PCDPauseDecoderState_EMIT2;
        end
      end

      PCDPauseDecoderState_EMIT2: begin
        // The counter was just cleared, so a pause end here is too short.
        if (pe) begin
          do_error = 1'b1;
        end else begin
          seq_valid_d = 1'b1;
          seq_d       = pend_seq_q;
          eoc_d       = pend_eoc_q;
          state_d     = pend_state_q;
        end
      end

      PCDPauseDecoderState_ERR_WAIT: begin
        // Pause ends just restart the quiet-time measurement.
        if (!pe && timeout) begin
          state_d = PCDPauseDecoderState_IDLE;
        end
      end

      default: state_d = PCDPauseDecoderState_IDLE;
    endcase

    if (do_error) begin
      seq_valid_d = 1'b1;
      seq_d       = PCDBitSequence_ERROR;
      soc_d       = 1'b0;
      eoc_d       = 1'b0;
      error_d     = 1'b1;
      state_d     = PCDPauseDecoderState_ERR_WAIT;
    end

    idle_d = (state_d == PCDPauseDecoderState_IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PCDPauseDecoderState_IDLE;
      pend_state_q <= PCDPauseDecoderState_IDLE;
      pend_seq_q   <= PCDBitSequence_ERROR;
      pend_eoc_q   <= 1'b0;
      cnt_q        <= '0;
      seq_valid_q  <= 1'b0;
      seq_q        <= PCDBitSequence_ERROR;
      soc_q        <= 1'b0;
      eoc_q        <= 1'b0;
      error_q      <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      pend_state_q <= pend_state_d;
      pend_seq_q   <= pend_seq_d;
      pend_eoc_q   <= pend_eoc_d;
      cnt_q        <= cnt_d;
      seq_valid_q  <= seq_valid_d;
      seq_q        <= seq_d;
      soc_q        <= soc_d;
      eoc_q        <= eoc_d;
      error_q      <= error_d;
      idle_q       <= idle_d;
    end
  end

  assign seq_valid = seq_valid_q;
  assign seq       = seq_q;
  assign soc       = soc_q;
  assign eoc       = eoc_q;
  assign error     = error_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_pcd_pause_decoder.sv
// Bench for pcd_pause_decoder. The carrier runs at TC time units per tick;
// the PICC clock is gated off STOP_DLY after each pause starts and restarts
// START_DLY after it ends, like the analogue front end does. Frames are
// described as X/Y/Z strings; Z pauses at bit start, X at mid-bit, Y has
// no pause. Each emitted sequence is packed as {b2b, seq, soc, eoc, error}
// where b2b means "strobe on the cycle right after the previous strobe".
module tb_pcd_pause_decoder;
  import ISO14443A_pkg::*;

  localparam int TC        = 74;
  localparam int HALF      = 37;
  localparam int BIT       = 128;
  localparam int GAP       = 340;
  localparam int STOP_DLY  = 200;
  localparam int START_DLY = 300;
  localparam int W         = 6;

  logic          clk;
  logic          clk_run;
  logic          rst_n;
  logic          pause_n;
  logic          seq_valid;
  PCDBitSequence seq;
  logic          soc;
  logic          eoc;
  logic          error;
  logic          idle;

  logic [W-1:0]  exp_q[$];
  PCDBitSequence frame_q[$];
  int            n_vec = 0;
  int            n_miss = 0;
  int            cyc = 0;
  int            last_cyc = -10;
  logic [W-1:0]  mon_act;
  logic [W-1:0]  mon_exp;

  pcd_pause_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pause_n   (pause_n),
    .seq_valid (seq_valid),
    .seq       (seq),
    .soc       (soc),
    .eoc       (eoc),
    .error     (error),
    .idle      (idle)
  );

  // ---------------- clock / reset block ----------------
  // Gated PICC clock: once stopped it finishes its high phase and stays low.
  initial begin
    clk = 1'b0;
    forever begin
      #HALF;
      if (clk_run || clk) clk = ~clk;
    end
  end

  // Front-end clock gating that follows the field pauses.
  initial begin
    clk_run = 1'b1;
    forever begin
      @(negedge pause_n);
      #(STOP_DLY);
      clk_run = 1'b0;
      @(posedge pause_n);
      #(START_DLY);
      clk_run = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached with %0d expected items left", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [W-1:0] pack(input logic b2b, input PCDBitSequence s,
                                        input logic so, input logic eo, input logic er);
    return {b2b, s, so, eo, er};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input string s);
    frame_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "X":     frame_q.push_back(PCDBitSequence_X);
        "Y":     frame_q.push_back(PCDBitSequence_Y);
        default: frame_q.push_back(PCDBitSequence_Z);
      endcase
    end
  endtask

  task automatic do_pause(input int len);
    pause_n = 1'b0;
    #(len * TC);
    pause_n = 1'b1;
  endtask

  // Plays frame_q; the decoder must echo every sequence, soc on the first,
  // eoc on the last, and a silent Y's successor arrives back-to-back.
  task automatic play_frame(input int pause_len);
    int n;
    int pos;
    int p;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pack((i > 0) ? (frame_q[i-1] == PCDBitSequence_Y) : 1'b0,
                           frame_q[i], i == 0, i == n - 1, 1'b0));
    end
    @(negedge clk);
    #7;
    pos = 0;
    for (int i = 0; i < n; i++) begin
      if (frame_q[i] != PCDBitSequence_Y) begin
        p = i * BIT + ((frame_q[i] == PCDBitSequence_X) ? BIT / 2 : 0);
        #((p - pos) * TC);
        do_pause(pause_len);
        pos = p + pause_len;
      end
    end
    #(GAP * TC);
    @(negedge clk);
    check("end_idle", idle, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && seq_valid) begin
        mon_act = {(cyc == last_cyc + 1), seq, soc, eoc, error};
        last_cyc = cyc;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL stream_extra: got b2b/seq/soc/eoc/err=%b expected nothing", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_miss++;
            $display("FAIL stream: got b2b/seq/soc/eoc/err=%b expected %b", mon_act, mon_exp);
          end
        end
      end else if (rst_n && (soc || eoc || error)) begin
        n_vec++;
        n_miss++;
        $display("FAIL strobe: soc/eoc/err=%b%b%b without seq_valid, expected 000", soc, eoc, error);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    pause_n = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", seq_valid, 0);
    check("rst_seq", int'(seq), int'(PCDBitSequence_ERROR));
    check("rst_soc", soc, 0);
    check("rst_eoc", eoc, 0);
    check("rst_error", error, 0);
    check("rst_idle", idle, 1);
    rst_n = 1'b1;

    // Data 0 frame: SOC Z, 0 -> Z, end Y.
    load("ZZY");
    play_frame(32);

    // 0x26 short frame, LSB first 0,1,1,0,0,1,0 then EOC (0 -> Z, Y):
    // Z | Z X X Y Z X Y | Z Y
    load("ZZXXYZXYZY");
    play_frame(32);

    // X then 1.5-bit gap (Y,Z back-to-back), and X then 2-bit gap (Y,X),
    // the latter also ending on the double-Y timeout after an X.
    load("ZXYZZY");
    play_frame(32);
    load("ZXYXYY");
    play_frame(32);

    // Two pauses 40 ticks apart: Z (soc) then ERROR, then silence.
    exp_q.push_back(pack(1'b0, PCDBitSequence_Z, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(pack(1'b0, PCDBitSequence_ERROR, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    #7;
    do_pause(32);
    #(8 * TC);
    do_pause(32);
    #(GAP * TC);
    @(negedge clk);
    check("err_idle", idle, 1);
    load("ZZY");
    play_frame(32);

    // Same frame with short and long pauses decodes identically.
    load("ZZXXYZXYZY");
    play_frame(28);
    play_frame(48);

    // Reset in the middle of a frame: no eoc, next frame starts with soc.
    exp_q.push_back(pack(1'b0, PCDBitSequence_Z, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    #7;
    do_pause(32);
    #(100 * TC);
    @(negedge clk);
    check("mid_idle", idle, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_valid", seq_valid, 0);
    check("mr_seq", int'(seq), int'(PCDBitSequence_ERROR));
    check("mr_soc", soc, 0);
    check("mr_eoc", eoc, 0);
    check("mr_error", error, 0);
    check("mr_idle", idle, 1);
    rst_n = 1'b1;
    #(GAP * TC);
    load("ZZY");
    play_frame(32);

    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
